next_pc_select_reg: RTL and testbench



---
 rtl/next_pc_pkg.sv | 14 +
 rtl/mux_n.sv | 26 ++
 rtl/next_pc_select_reg.sv | 78 +++++++
 tb/tb_next_pc_select_reg.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/next_pc_pkg.sv
// Shared constants for the fetch-stage next-PC selection logic.
// Select codes are fixed so decode and fetch agree on source numbering.
package next_pc_pkg;

    localparam int          DATABIT_DEF  = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

    localparam int unsigned SEL_SEQ = 0;
    localparam int unsigned SEL_BEQ = 1;
    localparam int unsigned SEL_J   = 2;
    localparam int unsigned SEL_JR  = 3;
    localparam int unsigned SEL_BNE = 4;

endpackage

// File: rtl/mux_n.sv
// Generic NUM-to-1 word mux over a flattened bus; an out-of-range select
// falls back to word 0 and raises out_of_range.
module mux_n #(
    parameter int WIDTH = 32,
    parameter int NUM   = 5,
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]     sel,
    input  logic [NUM*WIDTH-1:0] src,
    output logic [WIDTH-1:0]     out,
    output logic                 out_of_range
);

    assign out_of_range = (32'(sel) >= NUM);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        out = src[0 +: WIDTH];
        for (int k = 1; k < NUM; k++) begin
            if (32'(sel) == k) begin
                out = src[k*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/next_pc_select_reg.sv
// Fetch-stage PC register: picks the next PC from NUM_SRC candidates, holds
// under stall and buffers a redirect seen during a stall until release.
module next_pc_select_reg
    import next_pc_pkg::*;
#(
    parameter int                 DATABIT  = DATABIT_DEF,
    parameter int                 NUM_SRC  = 5,
    parameter int                 SEL_W    = 3,
    parameter logic [DATABIT-1:0] RESET_PC = DATABIT'(RESET_PC_DEF),
    parameter int                 CNT_W    = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic [SEL_W-1:0]           sel,
    input  logic [NUM_SRC*DATABIT-1:0] src,
    output logic [DATABIT-1:0]         pc,
    output logic                       redirect_pending,
    output logic                       redirect_taken,
    output logic                       sel_err,
    output logic [CNT_W-1:0]           redirect_cnt
);

    logic [DATABIT-1:0] cand;
    logic [DATABIT-1:0] pend_addr;
    logic               out_of_range;
    logic               is_redirect;
    logic               take_next;

    mux_n #(
        .WIDTH (DATABIT),
        .NUM   (NUM_SRC),
        .SEL_W (SEL_W)
    ) u_mux (
        .sel          (sel),
        .src          (src),
        .out          (cand),
        .out_of_range (out_of_range)
    );

    // A clamped select reads source 0, which is the sequential path, not a redirect.
    assign is_redirect = !out_of_range && (sel != SEL_W'(SEL_SEQ));
    assign take_next   = !stall && (is_redirect || redirect_pending);

    // NOTE: state registers use non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        param_ok: assert (NUM_SRC >= 2 && (1 << SEL_W) >= NUM_SRC);
        if (reset) begin
            pc               <= RESET_PC;
            redirect_pending <= 1'b0;
            pend_addr        <= '0;
            redirect_taken   <= 1'b0;
            sel_err          <= 1'b0;
            redirect_cnt     <= '0;
        end else begin
            if (out_of_range) begin
                sel_err <= 1'b1;
            end

            if (stall) begin
                if (is_redirect) begin
                    pend_addr        <= cand;
                    redirect_pending <= 1'b1;
                end
            end else begin
                // A fresh redirect outranks the buffered one; sequential yields to it.
                pc               <= (redirect_pending && !is_redirect) ? pend_addr : cand;
                redirect_pending <= 1'b0;
            end

            redirect_taken <= take_next;
            if (take_next && (redirect_cnt != {CNT_W{1'b1}})) begin
                redirect_cnt <= redirect_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_next_pc_select_reg.sv
// Random plus directed stimulus against a behavioural next-PC model; two
// DUT copies share inputs, one with a 2-bit counter to exercise saturation.
module tb_next_pc_select_reg;

    localparam int NSRC = 5;
    localparam int DW   = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall;
    logic [2:0]        sel;
    logic [DW-1:0]     src_arr [NSRC];
    logic [NSRC*DW-1:0] src_flat;

    logic [DW-1:0] pc, pc_s;
    logic          pend, pend_s, taken, taken_s, err, err_s;
    logic [15:0]   cnt;
    logic [1:0]    cnt_s;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    // Behavioural model state
    logic [DW-1:0] m_pc = 32'h3000;
    logic [DW-1:0] m_pend_addr = '0;
    bit            m_pend = 0, m_taken = 0, m_err = 0;
    int            m_cnt = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int k = 0; k < NSRC; k++) src_flat[k*DW +: DW] = src_arr[k];
    end

    next_pc_select_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .sel(sel), .src(src_flat),
        .pc(pc), .redirect_pending(pend), .redirect_taken(taken),
        .sel_err(err), .redirect_cnt(cnt)
    );

    next_pc_select_reg #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .stall(stall), .sel(sel), .src(src_flat),
        .pc(pc_s), .redirect_pending(pend_s), .redirect_taken(taken_s),
        .sel_err(err_s), .redirect_cnt(cnt_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    // Reference: the spec's per-edge rules applied to the values present before the edge.
    always @(posedge clk) begin
        int unsigned   s;
        logic [DW-1:0] c;
        s = (sel < NSRC) ? sel : 0;
        c = src_arr[s];
        if (reset) begin
            m_pc = 32'h3000; m_pend = 0; m_pend_addr = '0;
            m_taken = 0; m_err = 0; m_cnt = 0;
        end else begin
            if (sel >= NSRC) m_err = 1;
            if (stall) begin
                m_taken = 0;
                if (s != 0) begin
                    m_pend = 1;
                    m_pend_addr = c;
                end
            end else begin
                if (m_pend) begin
                    m_pc = (s != 0) ? c : m_pend_addr;
                    m_taken = 1;
                    m_pend = 0;
                end else begin
                    m_pc = c;
                    m_taken = (s != 0);
                end
                if (m_taken) m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("pc", pc, m_pc);
            check("pending", 32'(pend), 32'(m_pend));
            check("taken", 32'(taken), 32'(m_taken));
            check("sel_err", 32'(err), 32'(m_err));
            check("cnt", 32'(cnt), 32'(sat(m_cnt, 65535)));
            check("pc_sat_inst", pc_s, m_pc);
            check("cnt_sat_inst", 32'(cnt_s), 32'(sat(m_cnt, 3)));
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic rand_src();
        for (int k = 0; k < NSRC; k++) src_arr[k] = $urandom;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; sel = '0;
        rand_src();
        #1;
        tick();
        check_en = 1'b1;

        // 1: reset state, then a sequential step
        check("t1_reset_pc", pc, 32'h3000);
        check("t1_reset_cnt", 32'(cnt), 32'd0);
        check("t1_reset_err", 32'(err), 32'd0);
        reset = 1'b0; sel = 3'd0; rand_src(); src_arr[0] = 32'h3004;
        tick();
        check("t1_pc", pc, 32'h3004);
        check("t1_taken", 32'(taken), 32'd0);
        check("t1_cnt", 32'(cnt), 32'd0);

        // 2: jump
        sel = 3'd2; rand_src(); src_arr[2] = 32'h0040_0100;
        tick();
        check("t2_pc", pc, 32'h0040_0100);
        check("t2_taken", 32'(taken), 32'd1);
        check("t2_cnt", 32'(cnt), 32'd1);
        sel = 3'd0; rand_src(); src_arr[0] = 32'h0040_0104;
        tick();
        check("t2_taken_pulse", 32'(taken), 32'd0);

        // 3: redirect buffered during a stall, applied on release
        stall = 1'b1; sel = 3'd1; rand_src(); src_arr[1] = 32'h3020;
        tick();
        check("t3_hold0", pc, 32'h0040_0104);
        check("t3_pend0", 32'(pend), 32'd1);
        sel = 3'd0;
        for (int i = 0; i < 2; i++) begin
            rand_src();
            tick();
            check("t3_hold", pc, 32'h0040_0104);
            check("t3_pend", 32'(pend), 32'd1);
        end
        stall = 1'b0; rand_src();
        tick();
        check("t3_pc", pc, 32'h3020);
        check("t3_pend_clr", 32'(pend), 32'd0);
        check("t3_taken", 32'(taken), 32'd1);
        check("t3_cnt", 32'(cnt), 32'd2);

        // 4: new redirect overrides a buffered one
        stall = 1'b1; sel = 3'd1; rand_src(); src_arr[1] = 32'h3020;
        tick();
        stall = 1'b0; sel = 3'd4; rand_src(); src_arr[4] = 32'h3100;
        tick();
        check("t4_pc", pc, 32'h3100);
        check("t4_pend", 32'(pend), 32'd0);
        check("t4_cnt", 32'(cnt), 32'd3);

        // 5: out-of-range select falls back to sequential and sticks sel_err
        sel = 3'b111; rand_src(); src_arr[0] = 32'h3008;
        tick();
        check("t5_pc", pc, 32'h3008);
        check("t5_err", 32'(err), 32'd1);
        check("t5_taken", 32'(taken), 32'd0);
        sel = 3'd1; rand_src(); src_arr[1] = 32'h3200;
        tick();
        check("t5_err_sticky", 32'(err), 32'd1);
        check("t5_cnt", 32'(cnt), 32'd4);

        // 6: saturation of the 2-bit counter, then reset discarding a pending redirect
        reset = 1'b1; tick(); reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sel = 3'd2; rand_src();
            tick();
            check("t6_cnt_sat", 32'(cnt_s), (i < 3) ? i + 1 : 3);
        end
        stall = 1'b1; sel = 3'd3; rand_src();
        tick();
        check("t6_pend", 32'(pend), 32'd1);
        reset = 1'b1;
        tick();
        check("t6_reset_pc", pc, 32'h3000);
        check("t6_reset_pend", 32'(pend), 32'd0);
        reset = 1'b0; stall = 1'b0; sel = 3'd0; rand_src(); src_arr[0] = 32'h3004;
        tick();
        check("t6_discarded", pc, 32'h3004);

        // Random phase, checked every cycle by the compare process
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            stall = ($urandom_range(0, 9) < 3);
            sel   = 3'($urandom_range(0, 7));
            rand_src();
            tick();
        end

        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
